mcu_buffer: RTL and testbench

Parametrised MCU reassembly buffer between `loeffler2d_idct` and the colour-conversion stage of the JPEG decoder. It collects consecutive per-channel 8×8 pixel blocks into complete MCUs of `CH` blocks and stores up to `DEPTH` MCUs. Each finished MCU is presented under a valid/ready handshake. It also drives an accept-ok hint that the top level ANDs into the entropy decoder's `request`, stalling input before storage overflows, and it detects out-of-order channel sequences.

---
 rtl/mcu_buffer_pkg.sv | 13 +
 rtl/mcu_fifo_ctrl.sv | 65 ++++++
 rtl/mcu_buffer.sv | 147 ++++++++++++++
 tb/tb_mcu_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_buffer_pkg.sv
// Shared definitions for the MCU reassembly buffer: default geometry and FSM state encoding.
package mcu_buffer_pkg;

  localparam int MCUB_CH    = 3;
  localparam int MCUB_PIX_W = 8;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    RESYNC    = 2'd1,
    FULL_WAIT = 2'd2
  } MCUB_STATE;

endpackage

// File: rtl/mcu_fifo_ctrl.sv
// Slot bookkeeping for the MCU buffer: write/read pointers, occupancy, delivered count and accept hint.
module mcu_fifo_ctrl #(
  parameter int DEPTH     = 2,
  parameter int AF_MARGIN = 1,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_commit,
  input  logic             i_ready,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic             o_valid,
  output logic             o_full,
  output logic             o_accept_ok,
  output logic [15:0]      o_mcu_cnt
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_accept_ok;
  logic [15:0]      r_mcu_cnt;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_pop = i_ready && (r_count != '0);

  // Simultaneous commit and pop leave occupancy unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (i_commit && !w_pop)
      w_count_nxt = r_count + CNT_W'(1);
    else if (!i_commit && w_pop)
      w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_accept_ok <= 1'b1;
      r_mcu_cnt   <= '0;
    end else begin
      if (i_commit)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_mcu_cnt <= r_mcu_cnt + 16'd1;
      end
      r_count     <= w_count_nxt;
      r_accept_ok <= (w_count_nxt < CNT_W'(DEPTH - AF_MARGIN));
    end
  end

  assign o_wr_ptr    = r_wr_ptr;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_valid     = (r_count != '0);
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_accept_ok = r_accept_ok;
  assign o_mcu_cnt   = r_mcu_cnt;

endmodule

// File: rtl/mcu_buffer.sv
// Collects per-channel 8x8 IDCT blocks into complete MCUs, holds up to DEPTH of them and
// presents each under valid/ready, flagging out-of-order channels and overflow.
module mcu_buffer
  import mcu_buffer_pkg::*;
#(
  parameter int CH        = MCUB_CH,
  parameter int PIX_W     = MCUB_PIX_W,
  parameter int DEPTH     = 2,
  parameter int AF_MARGIN = 1,
  localparam int CH_W     = $clog2(CH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_in,
  input  logic [CH_W-1:0]                    channel_in,
  input  logic [7:0][7:0][PIX_W-1:0]         block_in,
  output logic                               accept_ok,
  output logic                               valid_out,
  input  logic                               ready_out,
  output logic [CH-1:0][7:0][7:0][PIX_W-1:0] mcu_out,
  output logic [15:0]                        mcu_cnt,
  output logic                               seq_err,
  output logic                               ovf_err
);

  // Handshake: an MCU transfers on every rising edge where valid_out and ready_out are both
  // high; valid_out never depends on ready_out, and mcu_out holds until that transfer.

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH - 1);

  typedef logic [7:0][7:0][PIX_W-1:0] PIX_BLOCK;
  typedef PIX_BLOCK [CH-1:0]          MCU_T;

  MCU_T             r_mem [DEPTH];
  MCUB_STATE        r_state;
  MCUB_STATE        w_state_nxt;
  logic [CH_W-1:0]  r_exp_ch;
  logic [CH_W-1:0]  w_exp_ch_nxt;
  logic             r_seq_err;
  logic             r_ovf_err;
  logic             w_acc;
  logic [CH_W-1:0]  w_acc_ch;
  logic             w_commit;
  logic             w_seq_set;
  logic             w_ovf_set;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_valid;
  logic             w_full;

  mcu_fifo_ctrl #(
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_commit    (w_commit),
    .i_ready     (ready_out),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_valid     (w_valid),
    .o_full      (w_full),
    .o_accept_ok (accept_ok),
    .o_mcu_cnt   (mcu_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FILL;
      r_exp_ch  <= '0;
      r_seq_err <= 1'b0;
      r_ovf_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_exp_ch  <= w_exp_ch_nxt;
      r_seq_err <= r_seq_err | w_seq_set;
      r_ovf_err <= r_ovf_err | w_ovf_set;
    end
  end

  // A channel-0 block always restarts the MCU in the current write slot, so a discarded
  // partial MCU is simply overwritten.
  always_comb begin
    w_state_nxt  = r_state;
    w_exp_ch_nxt = r_exp_ch;
    w_acc        = 1'b0;
    w_acc_ch     = r_exp_ch;
    w_seq_set    = 1'b0;
    w_ovf_set    = 1'b0;
    if (valid_in && w_full) begin
      w_ovf_set    = 1'b1;
      w_state_nxt  = RESYNC;
      w_exp_ch_nxt = '0;
    end else if (valid_in) begin
      case (r_state)
        RESYNC: begin
          if (channel_in == '0) begin
            w_acc    = 1'b1;
            w_acc_ch = '0;
          end
        end
        default: begin
          if (channel_in == r_exp_ch) begin
            w_acc    = 1'b1;
            w_acc_ch = r_exp_ch;
          end else begin
            w_seq_set    = 1'b1;
            w_exp_ch_nxt = '0;
            if (channel_in == '0) begin
              w_acc    = 1'b1;
              w_acc_ch = '0;
            end else begin
              w_state_nxt = RESYNC;
            end
          end
        end
      endcase
    end else if (r_state != RESYNC) begin
      w_state_nxt = w_full ? FULL_WAIT : FILL;
    end
    if (w_acc) begin
      w_state_nxt  = FILL;
      w_exp_ch_nxt = (w_acc_ch == LAST_CH) ? '0 : w_acc_ch + CH_W'(1);
    end
  end

  assign w_commit = w_acc && (w_acc_ch == LAST_CH);

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (w_acc && (w_acc_ch == CH_W'(c)))
        r_mem[w_wr_ptr][c] <= block_in;
    end
  end

  always_comb begin
    mcu_out = '0;
    if (w_valid)
      mcu_out = r_mem[w_rd_ptr];
  end

  assign valid_out = w_valid;
  assign seq_err   = r_seq_err;
  assign ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_mcu_buffer.sv
// Directed bench for mcu_buffer (CH=3, DEPTH=2, AF_MARGIN=1) with an MCU scoreboard.
module tb_mcu_buffer;

  localparam int CH    = 3;
  localparam int PIX_W = 8;
  localparam int BLK_W = 64 * PIX_W;
  localparam int MCU_W = CH * BLK_W;

  logic             clk;
  logic             rst;
  logic             valid_in;
  logic [1:0]       channel_in;
  logic [BLK_W-1:0] block_in;
  logic             accept_ok;
  logic             valid_out;
  logic             ready_out;
  logic [MCU_W-1:0] mcu_out;
  logic [15:0]      mcu_cnt;
  logic             seq_err;
  logic             ovf_err;

  logic [MCU_W-1:0] exp_q[$];
  int               n_checks;
  int               n_errors;
  int               exp_cnt;

  mcu_buffer #(
    .CH        (CH),
    .PIX_W     (PIX_W),
    .DEPTH     (2),
    .AF_MARGIN (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .channel_in (channel_in),
    .block_in   (block_in),
    .accept_ok  (accept_ok),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .mcu_out    (mcu_out),
    .mcu_cnt    (mcu_cnt),
    .seq_err    (seq_err),
    .ovf_err    (ovf_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [MCU_W-1:0] mk_mcu(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2);
    logic [MCU_W-1:0] m;
    for (int i = 0; i < 64; i++) begin
      m[i*8 +: 8]           = b0;
      m[BLK_W + i*8 +: 8]   = b1;
      m[2*BLK_W + i*8 +: 8] = b2;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_blk(input logic [1:0] ch, input logic [7:0] v);
    valid_in   = 1'b1;
    channel_in = ch;
    block_in   = {64{v}};
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send_mcu(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_q.push_back(mk_mcu(b0, b1, b2));
    send_blk(2'd0, b0);
    send_blk(2'd1, b1);
    send_blk(2'd2, b2);
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 20) begin
      @(posedge clk);
      #1;
      i++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s: %0d MCUs never delivered, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // scoreboard monitor: compares each MCU at the cycle it is handed over
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
    end else if (valid_out && ready_out) begin
      logic [MCU_W-1:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_mcu: got MCU byte0 0x%0h with nothing pending, required none",
                 mcu_out[7:0]);
      end else begin
        e = exp_q.pop_front();
        if (mcu_out !== e) begin
          n_errors++;
          for (int i = 0; i < MCU_W / 8; i++) begin
            if (mcu_out[i*8 +: 8] !== e[i*8 +: 8]) begin
              $display("FAIL mcu_data: byte %0d got 0x%0h, required 0x%0h",
                       i, mcu_out[i*8 +: 8], e[i*8 +: 8]);
              break;
            end
          end
        end
      end
      n_checks++;
      if (mcu_cnt !== 16'(exp_cnt)) begin
        n_errors++;
        $display("FAIL mcu_cnt_pre_pop: got %0d, required %0d", mcu_cnt, exp_cnt);
      end
      exp_cnt = exp_cnt + 1;
    end
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    exp_cnt    = 0;
    rst        = 1'b1;
    valid_in   = 1'b0;
    channel_in = 2'd0;
    block_in   = '0;
    ready_out  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // reset state
    chk("rst_valid_out", valid_out, 0);
    chk("rst_mcu_out_any", |mcu_out, 0);
    chk("rst_accept_ok", accept_ok, 1);
    chk("rst_mcu_cnt", mcu_cnt, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_ovf_err", ovf_err, 0);

    // single MCU straight through
    ready_out = 1'b1;
    send_mcu(8'h10, 8'h20, 8'h30);
    chk("basic_valid_latency", valid_out, 1);
    @(posedge clk);
    #1;
    chk("basic_mcu_cnt", mcu_cnt, 1);
    chk("basic_valid_after_pop", valid_out, 0);

    // fill both slots, then overflow
    do_reset();
    ready_out = 1'b0;
    send_mcu(8'h01, 8'h02, 8'h03);
    chk("fill_accept_ok_1", accept_ok, 0);
    send_mcu(8'h04, 8'h05, 8'h06);
    chk("fill_accept_ok_2", accept_ok, 0);
    chk("fill_valid", valid_out, 1);
    send_blk(2'd0, 8'h77);
    chk("ovf_flag", ovf_err, 1);
    chk("ovf_no_seq", seq_err, 0);
    ready_out = 1'b1;
    drain("ovf_drain");
    chk("ovf_empty_valid", valid_out, 0);
    chk("ovf_empty_accept_ok", accept_ok, 1);
    chk("ovf_flag_sticky", ovf_err, 1);

    // out-of-order channel, resync on next channel 0
    do_reset();
    ready_out = 1'b1;
    send_blk(2'd0, 8'h11);
    send_blk(2'd2, 8'h22);
    chk("seq_flag", seq_err, 1);
    chk("seq_no_ovf", ovf_err, 0);
    send_blk(2'd1, 8'h33);
    chk("resync_drop_valid", valid_out, 0);
    send_mcu(8'h55, 8'h55, 8'h55);
    drain("resync_drain");
    repeat (3) @(posedge clk);
    #1;
    chk("resync_single_mcu", valid_out, 0);
    chk("resync_mcu_cnt", mcu_cnt, 1);

    // restart mid-MCU on a fresh channel 0
    do_reset();
    ready_out = 1'b1;
    send_blk(2'd0, 8'hA0);
    send_blk(2'd1, 8'hA1);
    send_mcu(8'hB0, 8'hB1, 8'hB2);
    chk("restart_seq_flag", seq_err, 1);
    drain("restart_drain");

    // commit and pop in the same cycle
    do_reset();
    ready_out = 1'b0;
    send_mcu(8'hC1, 8'hC2, 8'hC3);
    exp_q.push_back(mk_mcu(8'hD1, 8'hD2, 8'hD3));
    send_blk(2'd0, 8'hD1);
    send_blk(2'd1, 8'hD2);
    ready_out = 1'b1;
    send_blk(2'd2, 8'hD3);
    chk("same_cycle_valid", valid_out, 1);
    chk("same_cycle_accept_ok", accept_ok, 0);
    chk("same_cycle_mcu_cnt", mcu_cnt, 1);
    drain("same_cycle_drain");
    chk("same_cycle_final_cnt", mcu_cnt, 2);

    // reset in the middle of an MCU
    do_reset();
    ready_out = 1'b1;
    send_blk(2'd0, 8'h01);
    send_blk(2'd2, 8'h02);
    send_blk(2'd0, 8'h03);
    send_blk(2'd1, 8'h04);
    chk("pre_rst_seq_flag", seq_err, 1);
    do_reset();
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_mcu_out_any", |mcu_out, 0);
    chk("midrst_accept_ok", accept_ok, 1);
    chk("midrst_seq_err", seq_err, 0);
    send_mcu(8'hE0, 8'hE1, 8'hE2);
    drain("midrst_drain");
    chk("midrst_mcu_cnt", mcu_cnt, 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
